reg_writeback: RTL and testbench
================================

// Module: reg_writeback
// PURPOSE
//   Write-back stage and register-file writer. Takes results from the ALU path and
//   the load path, buffers them in a small in-order FIFO, and issues at most one
//   register-file write per cycle on the rd_enable/rd_addr/rd_data port. Decode
//   uses the pending-check port to find registers whose writes are still in flight.
// PARAMETERS
//   REG_ADDR_W  5   register address width (x0..x31)
//   REG_W       32  register data width
//   DEPTH       4   FIFO entries; power of two, >= 2
// PORTS
//   clk          in   1           clock
//   rst          in   1           synchronous, active-high reset
//   ld_valid_i   in   1           load result valid
//   ld_rd_i      in   REG_ADDR_W  load destination register
//   ld_data_i    in   REG_W       load result
//   ld_ready_o   out  1           load result accepted when valid&ready
//   alu_valid_i  in   1           ALU result valid
//   alu_rd_i     in   REG_ADDR_W  ALU destination register
//   alu_data_i   in   REG_W       ALU result
//   alu_ready_o  out  1           ALU result accepted when valid&ready
//   rf_busy_i    in   1           register-file write port unavailable this cycle
//   rd_enable_o  out  1           register-file write enable (registered)
//   rd_addr_o    out  REG_ADDR_W  register-file write address (registered)
//   rd_data_o    out  REG_W       register-file write data (registered)
//   chk_addr_i   in   REG_ADDR_W  pending-check query address
//   chk_hit_o    out  1           a write to chk_addr_i is in flight (combinational)
//   chk_data_o   out  REG_W       youngest in-flight value for chk_addr_i (combinational)
// BEHAVIOUR
//   - Reset: FIFO empty (count, head, tail = 0); rd_enable_o=0, rd_addr_o=0, rd_data_o=0.
//     Entries queued at reset are discarded and never written.
//   - Accept: at most one push per cycle. ld has priority over alu.
//     ld_ready_o  = (count != DEPTH)
//     alu_ready_o = (count != DEPTH) && !ld_valid_i
//   - Accepted result with rd == 0: handshake completes; nothing is queued or written.
//   - At each posedge, in priority order:
//     1. rf_busy_i=1: rd_enable_o<=0, no pop; an accepted push goes into the FIFO.
//     2. count>0: pop head into rd_*_o with rd_enable_o<=1; an accepted push goes to tail.
//     3. count==0 and a push is accepted: bypass it into rd_*_o, rd_enable_o<=1.
//     4. Otherwise: rd_enable_o<=0. rd_addr_o and rd_data_o hold their last values.
//   - Latency: a push accepted in cycle N with an empty FIFO and rf_busy_i=0 makes
//     rd_enable_o=1 in cycle N+1. rd_enable_o is high for exactly one cycle per write.
//   - Ordering: writes leave strictly in acceptance order. No merging; two writes to the
//     same register both go out.
//   - Full plus pop in the same cycle: ready is based on registered count, so it stays
//     low that cycle. A push and a pop in one cycle leave count unchanged.
//   - Pointers wrap modulo DEPTH. Count width is $clog2(DEPTH+1).
//   - chk_hit_o = (chk_addr_i != 0) && (any valid FIFO entry matches,
//     or rd_enable_o && rd_addr_o == chk_addr_i).
//   - chk_data_o returns the youngest match: FIFO entries scanned from tail-1 back to
//     head, then rd_data_o. chk_data_o = 0 when chk_hit_o = 0.
//   - Incoming results in the current cycle are not visible on the chk port.
// TESTING
//   1. Idle; alu x5=0x12345678 in cycle N -> cycle N+1 rd_enable_o=1, rd_addr_o=5,
//      rd_data_o=0x12345678; N+2 rd_enable_o=0.
//   2. Same cycle ld x3=0xAA and alu x4=0xBB -> ld_ready_o=1, alu_ready_o=0; alu held
//      and accepted next cycle; writes x3 then x4 on consecutive cycles.
//   3. rf_busy_i=1 for 6 cycles with 5 back-to-back alu pushes -> 4 accepted, then
//      ready=0; busy released -> 4 writes in order, one per cycle; 5th accepted, written last.
//   4. alu rd=0 data=0xFFFFFFFF -> alu_ready_o=1; rd_enable_o stays 0; count unchanged.
//   5. Under busy, queue x7=1 then x7=2; chk_addr_i=7 -> chk_hit_o=1, chk_data_o=2;
//      chk_addr_i=0 -> chk_hit_o=0, chk_data_o=0.
//   6. 3 entries queued under busy, assert rst -> next cycle rd_enable_o=0, ready=1,
//      chk_hit_o=0; no writes after rst deasserts.

Source files
------------

// File: rtl/reg_writeback.sv
// Write-back stage: queues ALU/load results in an in-order FIFO and issues at most
// one register-file write per cycle; exposes in-flight writes to decode via chk port.
module reg_writeback #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned REG_W      = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_valid_i,
  input  logic [REG_ADDR_W-1:0] ld_rd_i,
  input  logic [REG_W-1:0]      ld_data_i,
  output logic                  ld_ready_o,
  input  logic                  alu_valid_i,
  input  logic [REG_ADDR_W-1:0] alu_rd_i,
  input  logic [REG_W-1:0]      alu_data_i,
  output logic                  alu_ready_o,
  input  logic                  rf_busy_i,
  output logic                  rd_enable_o,
  output logic [REG_ADDR_W-1:0] rd_addr_o,
  output logic [REG_W-1:0]      rd_data_o,
  input  logic [REG_ADDR_W-1:0] chk_addr_i,
  output logic                  chk_hit_o,
  output logic [REG_W-1:0]      chk_data_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]      head, tail;
  logic [CNT_W-1:0]      count;
  logic [REG_ADDR_W-1:0] q_addr [DEPTH];
  logic [REG_W-1:0]      q_data [DEPTH];

  logic                  not_full;
  logic                  push_fire, push_q, enq, do_pop, bypass;
  logic [REG_ADDR_W-1:0] push_addr;
  logic [REG_W-1:0]      push_data;

  assign not_full    = (count != CNT_W'(DEPTH));
  assign ld_ready_o  = not_full;
  assign alu_ready_o = not_full && !ld_valid_i;

  // Writes to x0 complete the handshake but are dropped before the FIFO.
  always_comb begin
    push_addr = ld_valid_i ? ld_rd_i   : alu_rd_i;
    push_data = ld_valid_i ? ld_data_i : alu_data_i;
    push_fire = (ld_valid_i && ld_ready_o) || (alu_valid_i && alu_ready_o);
    push_q    = push_fire && (push_addr != '0);
    do_pop    = !rf_busy_i && (count != '0);
    enq       = push_q && (rf_busy_i || (count != '0));
    bypass    = push_q && !rf_busy_i && (count == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      rd_enable_o <= 1'b0;
      rd_addr_o   <= '0;
      rd_data_o   <= '0;
    end else begin
      if (enq)    tail <= tail + PTR_W'(1);
      if (do_pop) head <= head + PTR_W'(1);
      if (enq && !do_pop)      count <= count + CNT_W'(1);
      else if (!enq && do_pop) count <= count - CNT_W'(1);

      if (do_pop) begin
        rd_enable_o <= 1'b1;
        rd_addr_o   <= q_addr[head];
        rd_data_o   <= q_data[head];
      end else if (bypass) begin
        rd_enable_o <= 1'b1;
        rd_addr_o   <= push_addr;
        rd_data_o   <= push_data;
      end else begin
        rd_enable_o <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      q_addr[tail] <= push_addr;
      q_data[tail] <= push_data;
    end
  end

  // Scan oldest to youngest so the youngest match overwrites; the output register is oldest.
  logic [PTR_W-1:0] scan_idx;
  always_comb begin
    chk_hit_o  = 1'b0;
    chk_data_o = '0;
    scan_idx   = '0;
    if (rd_enable_o && (rd_addr_o == chk_addr_i)) begin
      chk_hit_o  = 1'b1;
      chk_data_o = rd_data_o;
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      scan_idx = head + PTR_W'(i);
      if ((CNT_W'(i) < count) && (q_addr[scan_idx] == chk_addr_i)) begin
        chk_hit_o  = 1'b1;
        chk_data_o = q_data[scan_idx];
      end
    end
    if (chk_addr_i == '0) begin
      chk_hit_o  = 1'b0;
      chk_data_o = '0;
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: latency, priority, busy backpressure, x0 drop,
// pending-check youngest-match and reset discard.
module tb_reg_writeback;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ld_valid_i = 1'b0;
  logic [4:0]  ld_rd_i = '0;
  logic [31:0] ld_data_i = '0;
  logic        ld_ready_o;
  logic        alu_valid_i = 1'b0;
  logic [4:0]  alu_rd_i = '0;
  logic [31:0] alu_data_i = '0;
  logic        alu_ready_o;
  logic        rf_busy_i = 1'b0;
  logic        rd_enable_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;
  logic [4:0]  chk_addr_i = '0;
  logic        chk_hit_o;
  logic [31:0] chk_data_o;

  int tests = 0;
  int failed = 0;

  reg_writeback #(.REG_ADDR_W(5), .REG_W(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .ld_valid_i(ld_valid_i), .ld_rd_i(ld_rd_i), .ld_data_i(ld_data_i), .ld_ready_o(ld_ready_o),
    .alu_valid_i(alu_valid_i), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i), .alu_ready_o(alu_ready_o),
    .rf_busy_i(rf_busy_i),
    .rd_enable_o(rd_enable_o), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o),
    .chk_addr_i(chk_addr_i), .chk_hit_o(chk_hit_o), .chk_data_o(chk_data_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_wr(input string tag, input logic [4:0] a, input logic [31:0] d);
    check({tag, "_en"}, 32'(rd_enable_o), 32'd1);
    check({tag, "_addr"}, 32'(rd_addr_o), 32'(a));
    check({tag, "_data"}, rd_data_o, d);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    rst = 1'b0;
    chk_addr_i = 5'd5;
    #1;
    check("rst_en", 32'(rd_enable_o), 32'd0);
    check("rst_addr", 32'(rd_addr_o), 32'd0);
    check("rst_data", rd_data_o, 32'd0);
    check("rst_ldrdy", 32'(ld_ready_o), 32'd1);
    check("rst_alurdy", 32'(alu_ready_o), 32'd1);
    check("rst_hit", 32'(chk_hit_o), 32'd0);

    // 1: bypass latency
    alu_valid_i = 1'b1; alu_rd_i = 5'd5; alu_data_i = 32'h12345678;
    #1 check("t1_alurdy", 32'(alu_ready_o), 32'd1);
    tick();
    alu_valid_i = 1'b0;
    check_wr("t1_wr", 5'd5, 32'h12345678);
    check("t1_hit", 32'(chk_hit_o), 32'd1);
    check("t1_chkdata", chk_data_o, 32'h12345678);
    tick();
    check("t1_en_low", 32'(rd_enable_o), 32'd0);
    check("t1_hold_addr", 32'(rd_addr_o), 32'd5);
    check("t1_hold_data", rd_data_o, 32'h12345678);
    check("t1_hit_gone", 32'(chk_hit_o), 32'd0);

    // 2: ld priority over alu
    ld_valid_i = 1'b1; ld_rd_i = 5'd3; ld_data_i = 32'hAA;
    alu_valid_i = 1'b1; alu_rd_i = 5'd4; alu_data_i = 32'hBB;
    #1;
    check("t2_ldrdy", 32'(ld_ready_o), 32'd1);
    check("t2_alurdy", 32'(alu_ready_o), 32'd0);
    tick();
    ld_valid_i = 1'b0;
    #1 check("t2_alurdy2", 32'(alu_ready_o), 32'd1);
    check_wr("t2_wr3", 5'd3, 32'hAA);
    tick();
    alu_valid_i = 1'b0;
    check_wr("t2_wr4", 5'd4, 32'hBB);
    tick();
    check("t2_idle", 32'(rd_enable_o), 32'd0);

    // 3: busy backpressure, five pushes into a four-deep FIFO
    rf_busy_i = 1'b1;
    alu_valid_i = 1'b1; alu_rd_i = 5'd10; alu_data_i = 32'h100;
    #1 check("t3_rdy0", 32'(alu_ready_o), 32'd1);
    tick();
    check("t3_busy_en", 32'(rd_enable_o), 32'd0);
    alu_rd_i = 5'd11; alu_data_i = 32'h101;
    tick();
    alu_rd_i = 5'd12; alu_data_i = 32'h102;
    tick();
    alu_rd_i = 5'd13; alu_data_i = 32'h103;
    #1 check("t3_rdy3", 32'(alu_ready_o), 32'd1);
    tick();
    alu_rd_i = 5'd14; alu_data_i = 32'h104;
    #1;
    check("t3_full_alurdy", 32'(alu_ready_o), 32'd0);
    check("t3_full_ldrdy", 32'(ld_ready_o), 32'd0);
    tick();
    check("t3_stall_en", 32'(rd_enable_o), 32'd0);
    tick();
    check("t3_stall_en2", 32'(rd_enable_o), 32'd0);
    rf_busy_i = 1'b0;
    #1 check("t3_full_popcyc", 32'(alu_ready_o), 32'd0);
    tick();
    check_wr("t3_wr10", 5'd10, 32'h100);
    chk_addr_i = 5'd12;
    #1;
    check("t3_chk12_hit", 32'(chk_hit_o), 32'd1);
    check("t3_chk12_data", chk_data_o, 32'h102);
    check("t3_rdy_after_pop", 32'(alu_ready_o), 32'd1);
    tick();
    alu_valid_i = 1'b0;
    check_wr("t3_wr11", 5'd11, 32'h101);
    tick();
    check_wr("t3_wr12", 5'd12, 32'h102);
    tick();
    check_wr("t3_wr13", 5'd13, 32'h103);
    tick();
    check_wr("t3_wr14", 5'd14, 32'h104);
    tick();
    check("t3_idle", 32'(rd_enable_o), 32'd0);

    // 4: rd==0 accepted but dropped
    alu_valid_i = 1'b1; alu_rd_i = 5'd0; alu_data_i = 32'hFFFFFFFF;
    #1 check("t4_rdy", 32'(alu_ready_o), 32'd1);
    tick();
    alu_valid_i = 1'b0;
    check("t4_en", 32'(rd_enable_o), 32'd0);
    tick();
    check("t4_en2", 32'(rd_enable_o), 32'd0);
    rf_busy_i = 1'b1;
    alu_valid_i = 1'b1; alu_rd_i = 5'd1; alu_data_i = 32'h11;
    tick();
    alu_rd_i = 5'd2; alu_data_i = 32'h22;
    tick();
    alu_rd_i = 5'd3; alu_data_i = 32'h33;
    tick();
    alu_rd_i = 5'd0; alu_data_i = 32'hFFFFFFFF;
    tick();
    alu_valid_i = 1'b0;
    ld_valid_i = 1'b1; ld_rd_i = 5'd20; ld_data_i = 32'h2020;
    #1 check("t4_count_unchanged", 32'(ld_ready_o), 32'd1);
    tick();
    ld_valid_i = 1'b0;
    #1 check("t4_full", 32'(ld_ready_o), 32'd0);
    rf_busy_i = 1'b0;
    tick();
    check_wr("t4_wr1", 5'd1, 32'h11);
    tick();
    check_wr("t4_wr2", 5'd2, 32'h22);
    tick();
    check_wr("t4_wr3", 5'd3, 32'h33);
    tick();
    check_wr("t4_wr20", 5'd20, 32'h2020);
    tick();
    check("t4_idle", 32'(rd_enable_o), 32'd0);

    // 5: youngest-match pending check
    rf_busy_i = 1'b1;
    alu_valid_i = 1'b1; alu_rd_i = 5'd7; alu_data_i = 32'd1;
    tick();
    alu_data_i = 32'd2;
    chk_addr_i = 5'd7;
    #1;
    check("t5_hit1", 32'(chk_hit_o), 32'd1);
    check("t5_data1", chk_data_o, 32'd1);
    tick();
    alu_rd_i = 5'd9; alu_data_i = 32'd3;
    #1;
    check("t5_hit2", 32'(chk_hit_o), 32'd1);
    check("t5_data2", chk_data_o, 32'd2);
    chk_addr_i = 5'd0;
    #1;
    check("t5_x0_hit", 32'(chk_hit_o), 32'd0);
    check("t5_x0_data", chk_data_o, 32'd0);
    chk_addr_i = 5'd8;
    #1 check("t5_miss", 32'(chk_hit_o), 32'd0);
    tick();
    alu_valid_i = 1'b0;
    chk_addr_i = 5'd9;
    #1;
    check("t5_hit9", 32'(chk_hit_o), 32'd1);
    check("t5_data9", chk_data_o, 32'd3);

    // 6: reset discards queued entries
    rst = 1'b1;
    rf_busy_i = 1'b0;
    chk_addr_i = 5'd7;
    tick();
    rst = 1'b0;
    #1;
    check("t6_en", 32'(rd_enable_o), 32'd0);
    check("t6_ldrdy", 32'(ld_ready_o), 32'd1);
    check("t6_alurdy", 32'(alu_ready_o), 32'd1);
    check("t6_hit", 32'(chk_hit_o), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t6_no_write", 32'(rd_enable_o), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
